// File: rtl/machine_timer.sv
// Machine timer and software-interrupt source: 64-bit mtime/mtimecmp, msip bit,
// and a single-outstanding valid/ready register port feeding the CSR/trap block.
module machine_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);

    state_t      state;
    logic [15:0] prescale_count;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow_hi;
    logic        msip;

    logic        tick;
    logic        accept;
    logic        addr_ok;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_msip;
    logic        rd_mtime_lo;
    logic [31:0] rd_data;

    assign tick   = (prescale_count == LAST_COUNT);
    assign accept = (state == IDLE) && req_valid;

    always_comb begin
        addr_ok     = (req_addr[1:0] == 2'b00) && (req_addr[4:2] <= 3'd4);
        wr_mtime_lo = accept && req_write && addr_ok && (req_addr[4:2] == 3'd0);
        wr_mtime_hi = accept && req_write && addr_ok && (req_addr[4:2] == 3'd1);
        wr_cmp_lo   = accept && req_write && addr_ok && (req_addr[4:2] == 3'd2);
        wr_cmp_hi   = accept && req_write && addr_ok && (req_addr[4:2] == 3'd3);
        wr_msip     = accept && req_write && addr_ok && (req_addr[4:2] == 3'd4);
        rd_mtime_lo = accept && !req_write && addr_ok && (req_addr[4:2] == 3'd0);
    end

    // Reads of the high word come from the shadow so a lo-then-hi pair is atomic.
    always_comb begin
        rd_data = 32'd0;
        case (req_addr[4:2])
            3'd0:    rd_data = mtime[31:0];
            3'd1:    rd_data = shadow_hi;
            3'd2:    rd_data = mtimecmp[31:0];
            3'd3:    rd_data = mtimecmp[63:32];
            3'd4:    rd_data = {31'd0, msip};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_count <= 16'd0;
        end else if (tick) begin
            prescale_count <= 16'd0;
        end else begin
            prescale_count <= prescale_count + 16'd1;
        end
    end

    // A software write to either mtime half suppresses that cycle's increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtime <= 64'd0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= req_wdata;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= req_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mtimecmp        <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip            <= 1'b0;
            shadow_hi       <= 32'd0;
            timer_interrupt <= 1'b0;
        end else begin
            if (wr_cmp_lo) begin
                mtimecmp[31:0] <= req_wdata;
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= req_wdata;
            end
            if (wr_msip) begin
                msip <= req_wdata[0];
            end
            if (rd_mtime_lo) begin
                shadow_hi <= mtime[63:32];
            end
            timer_interrupt <= (mtime >= mtimecmp);
        end
    end

    assign software_interrupt = msip;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= RESP;
                        req_ready  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= (req_write || !addr_ok) ? 32'd0 : rd_data;
                        resp_error <= !addr_ok;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: two instances (PRESCALE 4 and 1) share one bus; a
// tick-counting reference model is compared on every cycle, plus literal checks.
module tb_machine_timer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [4:0]  req_addr = 5'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_ready = 1'b0;

    logic [1:0]  req_ready_w;
    logic [1:0]  resp_valid_w;
    logic [1:0]  resp_error_w;
    logic [1:0]  tirq_w;
    logic [1:0]  sirq_w;
    logic [31:0] rdata_w [2];

    int total = 0;
    int bad = 0;
    bit check_en = 1'b0;

    machine_timer #(.PRESCALE(4)) dut_p4 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready_w[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready),
        .resp_rdata(rdata_w[0]), .resp_error(resp_error_w[0]),
        .timer_interrupt(tirq_w[0]), .software_interrupt(sirq_w[0])
    );

    machine_timer #(.PRESCALE(1)) dut_p1 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready_w[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready),
        .resp_rdata(rdata_w[1]), .resp_error(resp_error_w[1]),
        .timer_interrupt(tirq_w[1]), .software_interrupt(sirq_w[1])
    );

    always #5 clk = ~clk;

    // Model: mtime = last written value + number of prescaler ticks since that write.
    longint      ecount = 0;
    longint      anchor_edge = -1;
    logic [63:0] anchor_val [2];
    logic [63:0] cmp_m [2];
    logic [31:0] shadow_m [2];
    logic [31:0] rdata_m [2];
    logic [1:0]  tirq_m;
    logic        msip_m;
    logic        busy_m;
    logic        err_m;

    function automatic logic [63:0] mtime_at(input int i, input longint e);
        longint p;
        p = (i == 0) ? 64'sd4 : 64'sd1;
        return anchor_val[i] + 64'(((e + 1) / p) - ((anchor_edge + 1) / p));
    endfunction

    function automatic logic addr_ok(input logic [4:0] a);
        return (a[1:0] == 2'b00) && (a[4:2] <= 3'd4);
    endfunction

    function automatic logic [31:0] read_val(input int i, input logic [4:0] a, input longint e);
        logic [63:0] now;
        now = mtime_at(i, e);
        case (a[4:2])
            3'd0:    return now[31:0];
            3'd1:    return shadow_m[i];
            3'd2:    return cmp_m[i][31:0];
            3'd3:    return cmp_m[i][63:32];
            3'd4:    return {31'd0, msip_m};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [63:0] merge_write(input logic [63:0] old, input logic hi, input logic [31:0] d);
        return hi ? {d, old[31:0]} : {old[63:32], d};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ecount      <= 0;
            anchor_edge <= -1;
            msip_m      <= 1'b0;
            busy_m      <= 1'b0;
            err_m       <= 1'b0;
            tirq_m      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                anchor_val[i] <= 64'd0;
                cmp_m[i]      <= 64'hFFFF_FFFF_FFFF_FFFF;
                shadow_m[i]   <= 32'd0;
                rdata_m[i]    <= 32'd0;
            end
        end else begin
            ecount <= ecount + 1;
            for (int i = 0; i < 2; i++) begin
                tirq_m[i] <= (mtime_at(i, ecount - 1) >= cmp_m[i]);
            end
            if (busy_m) begin
                if (resp_ready) busy_m <= 1'b0;
            end else if (req_valid) begin
                busy_m <= 1'b1;
                err_m  <= !addr_ok(req_addr);
                for (int i = 0; i < 2; i++) begin
                    rdata_m[i] <= (req_write || !addr_ok(req_addr)) ? 32'd0 : read_val(i, req_addr, ecount - 1);
                end
                if (addr_ok(req_addr)) begin
                    if (!req_write && req_addr[4:2] == 3'd0) begin
                        for (int i = 0; i < 2; i++) shadow_m[i] <= 32'(mtime_at(i, ecount - 1) >> 32);
                    end
                    if (req_write) begin
                        case (req_addr[4:2])
                            3'd0, 3'd1: begin
                                anchor_edge <= ecount;
                                for (int i = 0; i < 2; i++) begin
                                    anchor_val[i] <= merge_write(mtime_at(i, ecount - 1), req_addr[2], req_wdata);
                                end
                            end
                            3'd2: for (int i = 0; i < 2; i++) cmp_m[i] <= merge_write(cmp_m[i], 1'b0, req_wdata);
                            3'd3: for (int i = 0; i < 2; i++) cmp_m[i] <= merge_write(cmp_m[i], 1'b1, req_wdata);
                            3'd4: msip_m <= req_wdata[0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [63:0] act, input logic [63:0] lo, input logic [63:0] hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h..0x%0h", name, act, lo, hi);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("dut%0d req_ready", i), 64'(req_ready_w[i]), 64'(!busy_m));
                check($sformatf("dut%0d resp_valid", i), 64'(resp_valid_w[i]), 64'(busy_m));
                check($sformatf("dut%0d timer_interrupt", i), 64'(tirq_w[i]), 64'(tirq_m[i]));
                check($sformatf("dut%0d software_interrupt", i), 64'(sirq_w[i]), 64'(msip_m));
                if (busy_m) begin
                    check($sformatf("dut%0d resp_rdata", i), 64'(rdata_w[i]), 64'(rdata_m[i]));
                    check($sformatf("dut%0d resp_error", i), 64'(resp_error_w[i]), 64'(err_m));
                end
            end
        end
    end

    // One access: accept on the edge after the first negedge, handshake after `stall` cycles.
    task automatic applyStimulus(input logic wr, input logic [4:0] a, input logic [31:0] d, input int stall,
                                 output logic [31:0] r4, output logic [31:0] r1, output logic e);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        r4 = rdata_w[0];
        r1 = rdata_w[1];
        e  = resp_error_w[1];
        repeat (stall) @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] r4, r1, lo1, hi1, hi4;
        logic        e;
        int          k;

        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", 64'(req_ready_w), 64'h3);
        checkOutput("reset resp_valid", 64'(resp_valid_w), 64'h0);
        checkOutput("reset timer_interrupt", 64'(tirq_w), 64'h0);
        checkOutput("reset software_interrupt", 64'(sirq_w), 64'h0);
        checkOutput("reset resp_rdata", 64'(rdata_w[1]), 64'h0);
        checkOutput("reset resp_error", 64'(resp_error_w), 64'h0);
        check_en = 1'b1;
        reset_n  = 1'b1;

        repeat (39) @(negedge clk);
        applyStimulus(1'b0, 5'h00, 32'd0, 0, r4, r1, e);
        check_range("mtime after 40 cycles p4", 64'(r4), 64'd9, 64'd11);
        checkOutput("mtime after 40 cycles p1", 64'(r1), 64'd40);
        checkOutput("mtime read error", 64'(e), 64'd0);

        applyStimulus(1'b1, 5'h04, 32'd0, 0, r4, r1, e);
        applyStimulus(1'b1, 5'h00, 32'd0, 0, r4, r1, e);
        applyStimulus(1'b1, 5'h0C, 32'd0, 0, r4, r1, e);
        applyStimulus(1'b1, 5'h08, 32'd20, 0, r4, r1, e);
        k = 0;
        while (tirq_w[1] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("compare rise delay p1", 64'(k), 64'd14);
        applyStimulus(1'b1, 5'h08, 32'hFFFF_FFFF, 0, r4, r1, e);
        checkOutput("compare drop p1", 64'(tirq_w[1]), 64'd0);

        applyStimulus(1'b1, 5'h04, 32'd0, 0, r4, r1, e);
        applyStimulus(1'b1, 5'h00, 32'hFFFF_FFFC, 0, r4, r1, e);
        applyStimulus(1'b0, 5'h00, 32'd0, 0, r4, lo1, e);
        repeat (5) @(negedge clk);
        applyStimulus(1'b0, 5'h04, 32'd0, 0, hi4, hi1, e);
        checkOutput("atomic lo p1", 64'(lo1), 64'hFFFF_FFFE);
        checkOutput("atomic shadow hi p1", 64'(hi1), 64'h0);
        checkOutput("atomic shadow hi p4", 64'(hi4), 64'h0);
        applyStimulus(1'b0, 5'h00, 32'd0, 0, r4, r1, e);
        applyStimulus(1'b0, 5'h04, 32'd0, 0, r4, r1, e);
        checkOutput("live hi after carry p1", 64'(r1), 64'h1);

        applyStimulus(1'b1, 5'h0C, 32'd0, 0, r4, r1, e);
        applyStimulus(1'b1, 5'h08, 32'd5, 0, r4, r1, e);
        applyStimulus(1'b1, 5'h04, 32'hFFFF_FFFF, 0, r4, r1, e);
        applyStimulus(1'b1, 5'h00, 32'hFFFF_FFFF, 0, r4, r1, e);
        checkOutput("wrap irq before wrap p1", 64'(tirq_w[1]), 64'd1);
        @(negedge clk);
        checkOutput("wrap irq drop p1", 64'(tirq_w[1]), 64'd0);
        k = 1;
        while (tirq_w[1] !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("wrap irq return delay p1", 64'(k), 64'd6);

        applyStimulus(1'b0, 5'h10, 32'd0, 3, r4, r1, e);
        checkOutput("msip read initial", 64'({r4, r1}), 64'h0);
        applyStimulus(1'b1, 5'h10, 32'd1, 0, r4, r1, e);
        checkOutput("software_interrupt set", 64'(sirq_w), 64'h3);
        applyStimulus(1'b0, 5'h10, 32'd0, 0, r4, r1, e);
        checkOutput("msip read set", 64'(r1), 64'h1);
        applyStimulus(1'b1, 5'h10, 32'hFFFF_FFFE, 0, r4, r1, e);
        checkOutput("software_interrupt clear", 64'(sirq_w), 64'h0);

        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 5'h08;
        resp_ready = 1'b1;
        repeat (4) @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;

        applyStimulus(1'b0, 5'h14, 32'd0, 0, r4, r1, e);
        checkOutput("unmapped read error", 64'(e), 64'd1);
        checkOutput("unmapped read rdata", 64'(r1), 64'd0);
        applyStimulus(1'b1, 5'h02, 32'h1234, 0, r4, r1, e);
        checkOutput("misaligned write error", 64'(e), 64'd1);
        applyStimulus(1'b1, 5'h11, 32'd1, 0, r4, r1, e);
        checkOutput("misaligned msip write error", 64'(e), 64'd1);
        checkOutput("misaligned msip no effect", 64'(sirq_w), 64'h0);
        applyStimulus(1'b1, 5'h1C, 32'd7, 0, r4, r1, e);
        applyStimulus(1'b0, 5'h08, 32'd0, 0, r4, r1, e);
        checkOutput("mtimecmp lo unchanged p4", 64'(r4), 64'd5);
        checkOutput("mtimecmp lo unchanged p1", 64'(r1), 64'd5);

        k = 0;
        while ((ecount + 1) % 4 != 3 && k < 8) begin
            @(negedge clk);
            k++;
        end
        applyStimulus(1'b1, 5'h00, 32'h100, 0, r4, r1, e);
        applyStimulus(1'b0, 5'h00, 32'd0, 0, r4, r1, e);
        checkOutput("write on tick p4", 64'(r4), 64'h100);
        checkOutput("write on tick p1", 64'(r1), 64'h102);

        applyStimulus(1'b1, 5'h10, 32'd1, 0, r4, r1, e);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 5'h00;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("resp_valid before reset", 64'(resp_valid_w), 64'h3);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset mid-resp resp_valid", 64'(resp_valid_w), 64'h0);
        checkOutput("reset mid-resp req_ready", 64'(req_ready_w), 64'h3);
        checkOutput("reset mid-resp software_interrupt", 64'(sirq_w), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(1'b0, 5'h10, 32'd0, 0, r4, r1, e);
        checkOutput("msip after reset", 64'(r1), 64'd0);
        applyStimulus(1'b0, 5'h0C, 32'd0, 0, r4, r1, e);
        checkOutput("mtimecmp hi after reset", 64'(r4), 64'hFFFF_FFFF);
        checkOutput("timer_interrupt after reset", 64'(tirq_w), 64'h0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
